// File: rtl/serializer_pkg.sv
// Shared constants and state type for the parallel-to-serial core.
// Default word width, length-field width and the two-state FSM encoding.
package serializer_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_MOD_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;
endpackage

// File: rtl/serializer_core.sv
// MSB-first parallel-to-serial converter with a programmable frame length.
// A load is taken only when idle or on the last bit, so frames can run back to back.
module serializer_core
  import serializer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int MOD_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_val_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

  // One extra counter bit so a full-width frame (len = DATA_W) fits.
  localparam logic [MOD_W:0] FULL_LEN = (MOD_W+1)'(DATA_W);
  localparam logic [MOD_W:0] MIN_LEN  = (MOD_W+1)'(3);
  localparam logic [MOD_W:0] ONE      = (MOD_W+1)'(1);

  function automatic logic [MOD_W:0] eff_len(input logic [MOD_W-1:0] mod);
    return (mod == '0) ? FULL_LEN : {1'b0, mod};
  endfunction

  state_e            state_q, state_d;
  logic [MOD_W:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;

  logic           last_bit;
  logic           busy;
  logic [MOD_W:0] load_len;
  logic           accept;

  assign last_bit = (state_q == SEND) && (cnt_q == ONE);
  assign busy     = (state_q == SEND) && !last_bit;
  assign load_len = eff_len(data_mod_i);
  assign accept   = data_val_i && !busy && (load_len >= MIN_LEN);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shreg_d        = shreg_q;
    busy_o         = busy;
    ser_data_val_o = (state_q == SEND);
    ser_data_o     = (state_q == SEND) && shreg_q[DATA_W-1];

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          cnt_d   = load_len;
          shreg_d = data_i;
        end
      end
      SEND: begin
        if (last_bit) begin
          if (accept) begin
            cnt_d   = load_len;
            shreg_d = data_i;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d   = cnt_q - ONE;
          shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Shift data needs no reset: outputs are masked by the state while idle.
  always_ff @(posedge clk_i) begin
    shreg_q <= shreg_d;
  end

endmodule

// File: tb/tb_serializer_core.sv
// Bench for serializer_core: directed table, hand-written corner sequences and
// random frames checked against a queue-of-pending-bits reference model.
module tb_serializer_core;

  logic        clk_i = 1'b0;
  logic        arst_n_i;
  logic [15:0] data_i;
  logic        data_val_i;
  logic [3:0]  data_mod_i;
  logic        ser_data_o;
  logic        ser_data_val_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  // Bits still to appear on the serial line; front entry is the current cycle's bit.
  bit q[$];

  serializer_core #(.DATA_W(16), .MOD_W(4)) dut (
    .clk_i         (clk_i),
    .arst_n_i      (arst_n_i),
    .data_i        (data_i),
    .data_val_i    (data_val_i),
    .data_mod_i    (data_mod_i),
    .ser_data_o    (ser_data_o),
    .ser_data_val_o(ser_data_val_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic [3:0]  m;
    logic        es;
    logic        ev;
    logic        eb;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic ev, es, eb;
    ev = (q.size() > 0);
    es = ev ? q[0] : 1'b0;
    eb = (q.size() >= 2);
    check("model_val", ser_data_val_o, ev);
    check("model_data", ser_data_o, es);
    check("model_busy", busy_o, eb);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic step(input logic v, input logic [15:0] d, input logic [3:0] m);
    int len;
    bit acc;
    data_val_i = v;
    data_i     = d;
    data_mod_i = m;
    len = (m == 4'd0) ? 16 : int'(m);
    acc = v && (q.size() < 2) && (len >= 3);
    @(posedge clk_i);
    if (q.size() > 0) void'(q.pop_front());
    if (acc) for (int k = 0; k < len; k++) q.push_back(d[15-k]);
    @(negedge clk_i);
    data_val_i = 1'b0;
    check_model();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_val"}, ser_data_val_o, 1'b0);
    check({name, "_data"}, ser_data_o, 1'b0);
    check({name, "_busy"}, busy_o, 1'b0);
  endtask

  initial begin
    logic [15:0] w;
    logic        gap_seen;
    int          guard;

    arst_n_i   = 1'b0;
    data_i     = '0;
    data_val_i = 1'b0;
    data_mod_i = '0;
    #1;
    check_all_zero("reset_noclk");
    @(negedge clk_i);
    @(negedge clk_i);
    check_all_zero("reset_held");
    arst_n_i = 1'b1;

    // 6CF1 / len 5: bits 0,1,1,0,1; a load mid-frame is ignored; len 1 and 2 rejected.
    tbl[0] = '{1'b1, 16'h6CF1, 4'd5,  1'b0, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 16'h0000, 4'd0,  1'b1, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 16'h0000, 4'd0,  1'b1, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 16'hFFFF, 4'd7,  1'b0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 16'h0000, 4'd0,  1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 16'h0000, 4'd0,  1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 16'hFFFF, 4'd1,  1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 16'hFFFF, 4'd2,  1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 16'hC000, 4'd10, 1'b1, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 16'h0000, 4'd0,  1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].m);
      check($sformatf("tbl%0d_data", i), ser_data_o, tbl[i].es);
      check($sformatf("tbl%0d_val", i), ser_data_val_o, tbl[i].ev);
      check($sformatf("tbl%0d_busy", i), busy_o, tbl[i].eb);
    end
    for (int i = 0; i < 9; i++) step(1'b0, '0, '0);
    check_all_zero("after_len10");

    // Full-width frame, MSB first, busy drops only on the 16th bit.
    w = 16'h9A2F;
    for (int k = 0; k < 16; k++) begin
      step(k == 0, w, 4'd0);
      check($sformatf("full_bit%0d", k), ser_data_o, w[15-k]);
      check($sformatf("full_busy%0d", k), busy_o, k != 15);
    end
    step(1'b0, '0, '0);
    check_all_zero("after_full");

    // Back-to-back: new load on the last bit of a 3-bit frame, no gap.
    gap_seen = 1'b0;
    step(1'b1, 16'hACA9, 4'd3);
    step(1'b0, '0, '0);
    step(1'b0, '0, '0);
    check("b2b_lastbit", ser_data_o, 1'b1);
    step(1'b1, 16'h8C11, 4'd15);
    check("b2b_first", ser_data_o, 1'b1);
    for (int k = 1; k < 15; k++) begin
      if (!ser_data_val_o) gap_seen = 1'b1;
      step(1'b0, '0, '0);
    end
    check("b2b_nogap", gap_seen, 1'b0);
    step(1'b0, '0, '0);
    check_all_zero("after_b2b");

    // Reset mid-frame: outputs clear at once, nothing resumes after release.
    step(1'b1, 16'hFFFF, 4'd0);
    step(1'b0, '0, '0);
    step(1'b0, '0, '0);
    arst_n_i = 1'b0;
    #1;
    check_all_zero("midreset");
    q.delete();
    @(negedge clk_i);
    check_all_zero("midreset_held");
    arst_n_i = 1'b1;
    step(1'b0, '0, '0);
    step(1'b0, '0, '0);
    step(1'b1, 16'hA5A5, 4'd4);
    check("post_reset_load", ser_data_val_o, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0);

    // Random frames with idle gaps; junk loads while busy must be ignored.
    for (int n = 0; n < 1000; n++) begin
      guard = 0;
      while (q.size() >= 2 && guard < 40) begin
        step(1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom));
        guard++;
      end
      if (guard >= 40) begin
        bad++;
        total++;
        $display("FAIL rand_wait: busy for %0d cycles, required under 40", guard);
      end
      step(1'b1, 16'($urandom), 4'($urandom));
      for (int g = 0; g < int'($urandom_range(0, 5)); g++) step(1'b0, '0, '0);
    end
    for (int i = 0; i < 20; i++) step(1'b0, '0, '0);
    check_all_zero("final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
